sa_ctrl: RTL

Sequencer for the weight-stationary PE systolic array: ROWS x COLS PEs, each with a load_w / transpose_en weight path and a MAC psum path.
- On start it runs a weight-load phase, streams num_vec activation vectors, then drains the psum pipeline.
- Drives weight-buffer and activation-buffer read ports, the array-wide load_w and transpose_en, and a column-0 psum_valid strobe for the downstream deskew/writeback.
- Sits between the layer scheduler (start/done) and the array plus its SRAM buffers.

---
 rtl/sa_ctrl_pkg.sv | 18 +
 rtl/sa_phase_cnt.sv | 32 +++
 rtl/sa_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared types and helpers for the systolic-array sequencer.
package sa_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StStream,
    StDrain,
    StDone
  } state_e;

  // Cycles needed to push the last activation's psum out of the array.
  function automatic int unsigned drain_len(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/sa_phase_cnt.sv
// Up-counter with synchronous clear, parallel load, enable and terminal-count compare.
module sa_phase_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  // Clear wins over load, load wins over increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);

endmodule

// File: rtl/sa_ctrl.sv
// Sequencer for a weight-stationary systolic array: weight load, activation stream, psum drain.
module sa_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLS    = 4,
  parameter int unsigned VEC_W   = 16,
  parameter int unsigned WADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               transpose_cfg,
  input  logic [VEC_W-1:0]   num_vec,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               w_rd_en,
  output logic [WADDR_W-1:0] w_rd_addr,
  output logic               load_w,
  output logic               transpose_en,
  output logic               act_rd_en,
  output logic [VEC_W-1:0]   act_rd_addr,
  output logic               psum_valid,
  output logic [VEC_W-1:0]   psum_addr
);

  localparam logic [VEC_W-1:0] RowsM1  = VEC_W'(ROWS - 1);
  localparam logic [VEC_W-1:0] ColsM1  = VEC_W'(COLS - 1);
  localparam logic [VEC_W-1:0] DrainM1 = VEC_W'(drain_len(ROWS, COLS) - 1);

  state_e               state_q;
  logic                 tcfg_q;
  logic [VEC_W-1:0]     num_vec_q;
  logic                 busy_q, done_q, cfg_err_q;
  logic                 w_rd_en_q, load_w_q, transpose_en_q, act_rd_en_q;
  logic [WADDR_W-1:0]   w_rd_addr_q;
  // One tap per cycle from the FLUSH cycle: 1 buffer read cycle plus ROWS PE stages.
  logic [ROWS:0]        dly_q;
  logic                 psum_valid_q;

  logic [VEC_W-1:0]     phase_term, phase_cnt, act_cnt, psum_cnt, vec_term;
  logic                 phase_tc, phase_clr, act_tc, act_clr, psum_tc, psum_clr;

  // Phase length depends on which phase is running.
  always_comb begin
    phase_term = DrainM1;
    if (state_q == StLoad) begin
      phase_term = tcfg_q ? ColsM1 : RowsM1;
    end
  end

  assign vec_term  = num_vec_q - VEC_W'(1);
  assign phase_clr = !((state_q == StLoad) || (state_q == StDrain)) || phase_tc;
  assign act_clr   = (state_q != StStream) || act_tc;
  assign psum_clr  = !psum_valid_q || psum_tc;

  sa_phase_cnt #(.W(VEC_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (phase_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (1'b1),
    .term     (phase_term),
    .cnt      (phase_cnt),
    .tc       (phase_tc)
  );

  sa_phase_cnt #(.W(VEC_W)) u_act_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (act_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (1'b1),
    .term     (vec_term),
    .cnt      (act_cnt),
    .tc       (act_tc)
  );

  sa_phase_cnt #(.W(VEC_W)) u_psum_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (psum_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (1'b1),
    .term     (vec_term),
    .cnt      (psum_cnt),
    .tc       (psum_tc)
  );

  // Main sequencer FSM with registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      tcfg_q         <= 1'b0;
      num_vec_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
      w_rd_en_q      <= 1'b0;
      w_rd_addr_q    <= '0;
      load_w_q       <= 1'b0;
      transpose_en_q <= 1'b0;
      act_rd_en_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      // Weight data arrives one cycle after the read, so load_w trails w_rd_en.
      load_w_q  <= w_rd_en_q;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (num_vec == '0) begin
              cfg_err_q <= 1'b1;
            end else begin
              state_q        <= StLoad;
              tcfg_q         <= transpose_cfg;
              num_vec_q      <= num_vec;
              busy_q         <= 1'b1;
              w_rd_en_q      <= 1'b1;
              w_rd_addr_q    <= '0;
              transpose_en_q <= transpose_cfg;
            end
          end
        end
        StLoad: begin
          if (phase_tc) begin
            state_q     <= StFlush;
            w_rd_en_q   <= 1'b0;
            w_rd_addr_q <= '0;
          end else begin
            w_rd_addr_q <= w_rd_addr_q + WADDR_W'(1);
          end
        end
        StFlush: begin
          state_q     <= StStream;
          act_rd_en_q <= 1'b1;
        end
        StStream: begin
          if (act_tc) begin
            state_q     <= StDrain;
            act_rd_en_q <= 1'b0;
          end
        end
        StDrain: begin
          if (phase_tc) begin
            state_q        <= StDone;
            busy_q         <= 1'b0;
            done_q         <= 1'b1;
            transpose_en_q <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Psum strobe: delayed copy of stream start, then held for num_vec cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q        <= '0;
      psum_valid_q <= 1'b0;
    end else begin
      dly_q <= {dly_q[ROWS-1:0], state_q == StFlush};
      if (dly_q[ROWS]) begin
        psum_valid_q <= 1'b1;
      end else if (psum_tc) begin
        psum_valid_q <= 1'b0;
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign w_rd_en      = w_rd_en_q;
  assign w_rd_addr    = w_rd_addr_q;
  assign load_w       = load_w_q;
  assign transpose_en = transpose_en_q;
  assign act_rd_en    = act_rd_en_q;
  assign act_rd_addr  = act_cnt;
  assign psum_valid   = psum_valid_q;
  assign psum_addr    = psum_cnt;

endmodule
